// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding and BCD digit limit.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/decade_cnt.sv
// One BCD decade: counts 0..9 when enabled, wraps to 0; synchronous clear wins over enable.
module decade_cnt
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] q,
  output logic       co
);
  logic [3:0] r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (en) begin
      r_q <= (r_q == BCD_MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

  assign q  = r_q;
  assign co = en && (r_q == BCD_MAX);
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/pause/lap/clear FSM, tick prescaler and a cascade of BCD decades.
// Display shows the live count, or the snapshot captured on lap entry while in LAP.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int DIGITS   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start_stop,
  input  logic                lap,
  input  logic                clear,
  output logic [4*DIGITS-1:0] digits,
  output logic                running,
  output logic                lap_active,
  output logic                tick,
  output logic                overflow
);
  localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  sw_state_t            r_state;
  sw_state_t            w_next;
  logic                 w_clr;
  logic                 w_snap;
  logic                 w_run;
  logic                 w_tick;
  logic [PW-1:0]        r_presc;
  logic [4*DIGITS-1:0]  r_snap;
  logic                 r_ovf;
  logic [4*DIGITS-1:0]  w_live;
  logic [DIGITS-1:0]    w_en;
  logic [DIGITS-1:0]    w_co;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // clear beats start_stop beats lap; clear is only honoured while stopped
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_snap = 1'b0;
    case (r_state)
      IDLE: begin
        if (clear) begin
          w_clr = 1'b1;
        end else if (start_stop) begin
          w_next = RUN;
        end
      end
      RUN: begin
        if (start_stop) begin
          w_next = PAUSE;
        end else if (lap) begin
          w_next = LAP;
          w_snap = 1'b1;
        end
      end
      LAP: begin
        if (start_stop) begin
          w_next = PAUSE;
        end else if (lap) begin
          w_next = RUN;
        end
      end
      PAUSE: begin
        if (clear) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else if (start_stop) begin
          w_next = RUN;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_run  = (r_state == RUN) || (r_state == LAP);
  assign w_tick = w_run && (r_presc == PRESC_MAX);

  // prescaler holds while paused so a resume keeps the partial tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
    end else if (w_run) begin
      r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    end
  end

  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_dig
    if (g == 0) begin : g_first
      assign w_en[g] = w_tick;
    end else begin : g_rest
      assign w_en[g] = w_co[g-1];
    end
    decade_cnt u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (w_en[g]),
      .clr     (w_clr),
      .q       (w_live[4*g +: 4]),
      .co      (w_co[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_snap <= '0;
      end else if (w_snap) begin
        r_snap <= w_live;
      end
      if (w_clr) begin
        r_ovf <= 1'b0;
      end else if (w_co[DIGITS-1]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign digits     = (r_state == LAP) ? r_snap : w_live;
  assign running    = w_run;
  assign lap_active = (r_state == LAP);
  assign tick       = w_tick;
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DIGITS=2; inputs driven and outputs sampled on negedge.
module tb_stopwatch_ctrl;
  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       lap;
  logic       clear;
  logic [7:0] digits;
  logic       running;
  logic       lap_active;
  logic       tick;
  logic       overflow;

  int n_checks;
  int n_fail;

  stopwatch_ctrl #(.TICK_DIV(4), .DIGITS(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .tick       (tick),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Steps until n ticks have been seen and applied; reports cycles used.
  task automatic wait_ticks(input int n, output int cycles);
    int cnt;
    cnt    = 0;
    cycles = 0;
    while (cnt < n && cycles < 4 * n + 16) begin
      if (tick) cnt++;
      @(negedge clk);
      cycles++;
    end
    check_eq("tick_timeout", 32'(cnt), 32'(n));
  endtask

  initial begin
    int cyc;
    int ticks_seen;
    n_checks   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1. reset state
    check_eq("rst_digits", 32'(digits), 32'h00);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_lap_active", 32'(lap_active), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_tick", 32'(tick), 32'd0);

    // 2. start, 40 cycles: tick on every 4th cycle
    pulse_ss();
    check_eq("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 40; i++) begin
      check_eq("run_tick_phase", 32'(tick), 32'((i % 4) == 3));
      @(negedge clk);
    end
    check_eq("run_digits_10", 32'(digits), 32'h10);

    // 3. run to 99, then wrap with overflow
    wait_ticks(89, cyc);
    check_eq("digits_99", 32'(digits), 32'h99);
    check_eq("ovf_before_wrap", 32'(overflow), 32'd0);
    wait_ticks(1, cyc);
    check_eq("digits_wrap", 32'(digits), 32'h00);
    check_eq("ovf_set", 32'(overflow), 32'd1);
    pulse_clear();
    check_eq("clr_in_run_ovf", 32'(overflow), 32'd1);
    check_eq("clr_in_run_running", 32'(running), 32'd1);
    pulse_ss();
    check_eq("paused_running", 32'(running), 32'd0);
    pulse_clear();
    check_eq("clr_digits", 32'(digits), 32'h00);
    check_eq("clr_ovf", 32'(overflow), 32'd0);
    check_eq("clr_running", 32'(running), 32'd0);

    // 4. lap freeze at 12 while live count reaches 17
    pulse_ss();
    wait_ticks(12, cyc);
    check_eq("first_ticks_cycles", 32'(cyc), 32'd48);
    check_eq("digits_12", 32'(digits), 32'h12);
    pulse_lap();
    repeat (19) @(negedge clk);
    check_eq("lap_frozen", 32'(digits), 32'h12);
    check_eq("lap_active", 32'(lap_active), 32'd1);
    check_eq("lap_running", 32'(running), 32'd1);
    pulse_lap();
    check_eq("unlap_digits", 32'(digits), 32'h17);
    check_eq("unlap_lap_active", 32'(lap_active), 32'd0);

    // 5. pause keeps partial tick
    wait_ticks(1, cyc);
    check_eq("digits_18", 32'(digits), 32'h18);
    @(negedge clk);
    pulse_ss();
    ticks_seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (tick) ticks_seen++;
      @(negedge clk);
    end
    check_eq("pause_no_ticks", 32'(ticks_seen), 32'd0);
    check_eq("pause_digits", 32'(digits), 32'h18);
    pulse_ss();
    check_eq("resume_tick0", 32'(tick), 32'd0);
    @(negedge clk);
    check_eq("resume_tick1", 32'(tick), 32'd1);
    pulse_ss();
    check_eq("digits_19", 32'(digits), 32'h19);
    check_eq("pause2_running", 32'(running), 32'd0);
    clear      = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear      = 1'b0;
    start_stop = 1'b0;
    check_eq("clr_ss_digits", 32'(digits), 32'h00);
    check_eq("clr_ss_running", 32'(running), 32'd0);
    @(negedge clk);
    check_eq("clr_ss_idle", 32'(running), 32'd0);

    // 6. async reset mid-operation
    pulse_ss();
    wait_ticks(2, cyc);
    pulse_lap();
    check_eq("pre_rst_lap", 32'(lap_active), 32'd1);
    check_eq("pre_rst_digits", 32'(digits), 32'h02);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_digits", 32'(digits), 32'h00);
    check_eq("arst_running", 32'(running), 32'd0);
    check_eq("arst_lap_active", 32'(lap_active), 32'd0);
    check_eq("arst_tick", 32'(tick), 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("post_rst_running", 32'(running), 32'd0);
    check_eq("post_rst_digits", 32'(digits), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
